// File: rtl/mf8_pkg.sv
// Shared register map and bit positions for mf8 I/O peripherals.
package mf8_pkg;

    localparam logic [1:0] MBX_DATA   = 2'd0;
    localparam logic [1:0] MBX_STATUS = 2'd1;
    localparam logic [1:0] MBX_CTRL   = 2'd2;
    localparam logic [1:0] MBX_RXCNT  = 2'd3;

    localparam int unsigned ST_RX_AVAIL = 0;
    localparam int unsigned ST_TX_FULL  = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_TX_EMPTY = 3;
    localparam int unsigned ST_ERR      = 4;

    localparam int unsigned CTRL_IRQ_EN   = 0;
    localparam int unsigned CTRL_FLUSH_RX = 1;
    localparam int unsigned CTRL_FLUSH_TX = 2;
    localparam int unsigned CTRL_ERR_CLR  = 4;

endpackage

// File: rtl/mf8_sync_fifo.sv
// Synchronous FIFO with distributed storage and combinational head output.
module mf8_sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    // Empty FIFO presents zero rather than stale storage.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (!Reset && push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/mf8_io_mailbox.sv
// Byte mailbox between the mf8 I/O bus and host logic: RX/TX FIFOs,
// status/control registers and an RX-available interrupt.
module mf8_io_mailbox
    import mf8_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [5:0]  BASE_ADDR  = 6'h20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       IO_Rd,
    input  logic       IO_Wr,
    input  logic [5:0] IO_Addr,
    input  logic [7:0] IO_WData,
    output logic [7:0] IO_RData,
    input  logic       host_wr_valid,
    input  logic [7:0] host_wr_data,
    output logic       host_wr_ready,
    output logic       host_rd_valid,
    output logic [7:0] host_rd_data,
    input  logic       host_rd_ready,
    output logic       core_irq
);

    logic                hit;
    logic [1:0]          off;
    logic                wr_hit;
    logic                rd_hit;
    logic                rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic                tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic [7:0]          rx_dout;
    logic [DEPTH_LOG2:0] rx_count;
    logic [DEPTH_LOG2:0] tx_count;
    logic                err;
    logic                err_set;
    logic                rx_irq_en;
    logic                unused_wdata;

    assign hit    = (IO_Addr[5:2] == BASE_ADDR[5:2]);
    assign off    = IO_Addr[1:0];
    assign wr_hit = IO_Wr & hit;
    // A write strobe overrides a concurrent read, so no pop happens.
    assign rd_hit = IO_Rd & hit & ~IO_Wr;

    assign rx_push  = host_wr_valid & host_wr_ready;
    assign rx_pop   = rd_hit & (off == MBX_DATA) & ~rx_empty;
    assign rx_flush = wr_hit & (off == MBX_CTRL) & IO_WData[CTRL_FLUSH_RX];
    assign tx_push  = wr_hit & (off == MBX_DATA) & ~tx_full;
    assign tx_pop   = host_rd_valid & host_rd_ready;
    assign tx_flush = wr_hit & (off == MBX_CTRL) & IO_WData[CTRL_FLUSH_TX];

    assign err_set = (rd_hit & (off == MBX_DATA) & rx_empty)
                   | (wr_hit & (off == MBX_DATA) & tx_full);

    assign host_wr_ready = ~rx_full;
    assign host_rd_valid = ~tx_empty;
    assign core_irq      = ~rx_empty & rx_irq_en;
    assign unused_wdata  = ^{IO_WData[7:5], IO_WData[3]};

    mf8_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .din   (host_wr_data),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    mf8_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (IO_WData),
        .dout  (host_rd_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // Control and sticky error state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rx_irq_en <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (wr_hit && (off == MBX_CTRL)) begin
                rx_irq_en <= IO_WData[CTRL_IRQ_EN];
            end
            if (wr_hit && (off == MBX_CTRL) && IO_WData[CTRL_ERR_CLR]) begin
                err <= 1'b0;
            end else if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Read mux; zero outside the window.
    always_comb begin
        IO_RData = 8'h00;
        if (hit) begin
            case (off)
                MBX_DATA: IO_RData = rx_dout;
                MBX_STATUS: begin
                    IO_RData[ST_RX_AVAIL] = ~rx_empty;
                    IO_RData[ST_TX_FULL]  = tx_full;
                    IO_RData[ST_RX_FULL]  = rx_full;
                    IO_RData[ST_TX_EMPTY] = tx_empty;
                    IO_RData[ST_ERR]      = err;
                end
                MBX_CTRL:  IO_RData[CTRL_IRQ_EN] = rx_irq_en;
                default:   IO_RData = 8'(rx_count);
            endcase
        end
    end

    logic unused_tx_count;
    assign unused_tx_count = ^tx_count;

endmodule

// File: tb/tb_mf8_io_mailbox.sv
// Scoreboard bench for mf8_io_mailbox: directed stimulus queues expected
// bytes, a negedge monitor compares IO reads and host TX pops against them.
module tb_mf8_io_mailbox;

    localparam logic [5:0] BASE = 6'h20;
    localparam logic [5:0] A_DATA   = BASE + 6'd0;
    localparam logic [5:0] A_STATUS = BASE + 6'd1;
    localparam logic [5:0] A_CTRL   = BASE + 6'd2;
    localparam logic [5:0] A_RXCNT  = BASE + 6'd3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       IO_Rd = 1'b0;
    logic       IO_Wr = 1'b0;
    logic [5:0] IO_Addr = '0;
    logic [7:0] IO_WData = '0;
    logic [7:0] IO_RData;
    logic       host_wr_valid = 1'b0;
    logic [7:0] host_wr_data = '0;
    logic       host_wr_ready;
    logic       host_rd_valid;
    logic [7:0] host_rd_data;
    logic       host_rd_ready = 1'b0;
    logic       core_irq;

    int total = 0;
    int bad   = 0;
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];

    always #5 Clk = ~Clk;

    mf8_io_mailbox #(.DEPTH_LOG2(2), .BASE_ADDR(BASE)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .IO_Rd         (IO_Rd),
        .IO_Wr         (IO_Wr),
        .IO_Addr       (IO_Addr),
        .IO_WData      (IO_WData),
        .IO_RData      (IO_RData),
        .host_wr_valid (host_wr_valid),
        .host_wr_data  (host_wr_data),
        .host_wr_ready (host_wr_ready),
        .host_rd_valid (host_rd_valid),
        .host_rd_data  (host_rd_data),
        .host_rd_ready (host_rd_ready),
        .core_irq      (core_irq)
    );

    // Monitor: compare whatever the DUT presents against queued expectations.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (IO_Rd) begin
                total++;
                if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL io_read addr=%02h got=%02h but nothing expected", IO_Addr, IO_RData);
                end else begin
                    logic [7:0] e;
                    e = rd_q.pop_front();
                    if (IO_RData !== e) begin
                        bad++;
                        $display("FAIL io_read addr=%02h got=%02h exp=%02h", IO_Addr, IO_RData, e);
                    end
                end
            end
            if (host_rd_valid && host_rd_ready) begin
                total++;
                if (tx_q.size() == 0) begin
                    bad++;
                    $display("FAIL host_pop got=%02h but nothing expected", host_rd_data);
                end else begin
                    logic [7:0] e;
                    e = tx_q.pop_front();
                    if (host_rd_data !== e) begin
                        bad++;
                        $display("FAIL host_pop got=%02h exp=%02h", host_rd_data, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%02h exp=%02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic io_write(input logic [5:0] a, input logic [7:0] d);
        IO_Wr = 1'b1; IO_Addr = a; IO_WData = d;
        tick();
        IO_Wr = 1'b0;
    endtask

    task automatic io_read(input logic [5:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        IO_Rd = 1'b1; IO_Addr = a;
        tick();
        IO_Rd = 1'b0;
    endtask

    task automatic host_push(input logic [7:0] d);
        check("host_wr_ready_before_push", 8'(host_wr_ready), 8'h01);
        host_wr_valid = 1'b1; host_wr_data = d;
        tick();
        host_wr_valid = 1'b0;
    endtask

    task automatic host_pop(input logic [7:0] exp);
        tx_q.push_back(exp);
        host_rd_ready = 1'b1;
        tick();
        host_rd_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) tick();
        Reset = 1'b0;
        check("rst_wr_ready", 8'(host_wr_ready), 8'h01);
        check("rst_rd_valid", 8'(host_rd_valid), 8'h00);
        check("rst_irq", 8'(core_irq), 8'h00);
        check("rst_rd_data", host_rd_data, 8'h00);
        io_read(A_STATUS, 8'h08);

        // Host to core path
        host_push(8'hA5);
        host_push(8'h3C);
        io_read(A_RXCNT, 8'h02);
        io_read(A_DATA, 8'hA5);
        io_read(A_DATA, 8'h3C);
        io_read(A_STATUS, 8'h08);

        // Core to host with overflow
        for (int i = 1; i <= 5; i++) io_write(A_DATA, 8'(i));
        io_read(A_STATUS, 8'h12);
        for (int i = 1; i <= 4; i++) host_pop(8'(i));
        check("tx_drained_valid", 8'(host_rd_valid), 8'h00);
        io_write(A_CTRL, 8'h10);
        io_read(A_STATUS, 8'h08);

        // RX full with concurrent core pop and host offer
        for (int i = 0; i < 4; i++) host_push(8'h10 + 8'(i));
        io_read(A_STATUS, 8'h0D);
        rd_q.push_back(8'h10);
        IO_Rd = 1'b1; IO_Addr = A_DATA;
        host_wr_valid = 1'b1; host_wr_data = 8'h14;
        check("full_wr_ready_low", 8'(host_wr_ready), 8'h00);
        tick();
        IO_Rd = 1'b0;
        check("full_wr_ready_high", 8'(host_wr_ready), 8'h01);
        tick();
        host_wr_valid = 1'b0;
        io_read(A_RXCNT, 8'h04);
        for (int i = 1; i <= 4; i++) io_read(A_DATA, 8'h10 + 8'(i));

        // Interrupt and RX flush
        io_write(A_CTRL, 8'h01);
        check("irq_idle", 8'(core_irq), 8'h00);
        host_push(8'h55);
        check("irq_after_push", 8'(core_irq), 8'h01);
        io_write(A_CTRL, 8'h03);
        check("irq_after_flush", 8'(core_irq), 8'h00);
        io_read(A_RXCNT, 8'h00);
        io_read(A_CTRL, 8'h01);

        // Underflow and out-of-window accesses
        io_read(A_DATA, 8'h00);
        io_read(A_STATUS, 8'h18);
        io_write(BASE + 6'd4, 8'h77);
        check("oow_write_no_tx", 8'(host_rd_valid), 8'h00);
        io_read(BASE + 6'd4, 8'h00);
        io_read(BASE + 6'd5, 8'h00);
        io_write(A_CTRL, 8'h11);
        io_read(A_STATUS, 8'h08);

        // Reset mid-operation
        host_push(8'h66);
        io_write(A_DATA, 8'h99);
        Reset = 1'b1; host_wr_valid = 1'b1; host_wr_data = 8'h77;
        tick();
        Reset = 1'b0; host_wr_valid = 1'b0;
        check("midrst_rd_valid", 8'(host_rd_valid), 8'h00);
        check("midrst_rd_data", host_rd_data, 8'h00);
        io_read(A_STATUS, 8'h08);
        io_read(A_RXCNT, 8'h00);
        io_read(A_CTRL, 8'h00);

        repeat (3) tick();
        total++;
        if (rd_q.size() != 0 || tx_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations rd=%0d tx=%0d exp=0", rd_q.size(), tx_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
